shearsort_sequencer: RTL and testbench
======================================

// Module: shearsort_sequencer
// PURPOSE
//  Central controller for the N x N PE mesh. Broadcasts a registered opcode that
//  tells every PE each cycle which neighbour port to select (l/r/u/d) and which
//  compare-exchange step to run. Sequences a full shearsort: LOG_N row/column
//  phase pairs, then one final row phase. Each phase has N odd-even
//  transposition steps. Sits beside the mesh; one instance per array.
// PARAMETERS
//  N            4  mesh side length; steps per phase
//  LOG_N        2  ceil(log2(N)); number of row+column phase pairs
//  SORT_CYCLES  1  cycles each step's opcode is held; must be >= 1
//  OP_WIDTH     4  opcode width
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  i_start    in   1         start request; sampled only in IDLE
//  i_abort    in   1         abandon the sort in progress
//  o_busy     out  1         high from the first op cycle through the last op cycle
//  o_done     out  1         one-cycle pulse after a sort completes normally
//  o_op       out  OP_WIDTH  broadcast opcode to all PEs
//  o_snake    out  1         1: odd rows sort descending (row phases only)
//  o_phase    out  $clog2(2*LOG_N+1)  current phase index, 0-based
//  o_step     out  $clog2(N)          current step index within the phase
// BEHAVIOUR
//  Opcodes: 0 NOP, 1 SLT_L, 2 SLT_R, 3 SLT_U, 4 SLT_D, 5 CS_ROW_EVEN,
//   6 CS_ROW_ODD, 7 CS_COL_EVEN, 8 CS_COL_ODD. Values 9..15 are never driven.
//  Reset: IDLE; o_op=0, o_busy=0, o_done=0, o_snake=0, o_phase=0, o_step=0.
//  FSM: IDLE -> ROW -> COL -> ROW ... -> FINAL_ROW -> DONE -> IDLE.
//   - Phases with even index 0,2,..,2*LOG_N-2 are ROW.
//   - Phases with odd index are COL.
//   - Phase 2*LOG_N is FINAL_ROW.
//  Start: i_start=1 in IDLE. The next cycle has o_busy=1, o_op=5, phase=0, step=0.
//  Step op: ROW/FINAL_ROW use 5 on even steps and 6 on odd steps. COL uses 7 on
//   even steps and 8 on odd steps.
//  Each op is held SORT_CYCLES cycles, counted by a cycle counter. At wrap the
//   step increments. At step==N-1 wrap the step goes to 0 and the phase increments.
//  o_snake=1 during ROW and FINAL_ROW, 0 during COL and IDLE.
//  Total busy cycles = (2*LOG_N+1)*N*SORT_CYCLES.
//  Completion: the cycle after the last op cycle has o_busy=0, o_done=1,
//   o_op=0 (DONE state). IDLE follows on the next cycle.
//  i_start while busy or in DONE: ignored, no queuing.
//  i_abort (priority over start, any non-IDLE state): the next cycle is IDLE.
//   o_busy=0, o_op=0, counters cleared, no o_done pulse.
//  i_abort in IDLE: no effect. Simultaneous i_start and i_abort in IDLE: the
//   start is taken.
//  Counter wrap is exact; phase never exceeds 2*LOG_N.
//  rst_n low mid-sort: immediate async return to reset values; no o_done.
// CONFIGURATION
//  SORT_PAUSE_EN defined:
//   - Adds input i_pause (1 bit). While i_pause=1 in ROW/COL/FINAL_ROW, all
//     counters freeze, o_op=0, o_busy stays 1, o_phase/o_step hold.
//   - When i_pause drops, the interrupted op resumes and is driven for its full
//     remaining cycle count.
//   - i_abort overrides pause.
//  SORT_PAUSE_EN undefined: port absent, no pause logic; a sort runs
//   uninterrupted unless aborted.
// TESTING (N=4, LOG_N=2, SORT_CYCLES=1 unless noted)
//  - Reset: rst_n=0 -> all outputs 0. Release, no start -> o_busy=0, o_op=0 stay.
//  - Full sort: pulse i_start -> 20 busy cycles. Op order per phase is 5,6,5,6
//    (phases 0,2,4) and 7,8,7,8 (phases 1,3). o_snake=1 only in phases 0,2,4.
//    o_done=1 on cycle 21 only.
//  - SORT_CYCLES=3: each op is held 3 cycles; 60 busy cycles; o_step changes
//    every 3rd cycle.
//  - Abort: i_abort at phase=1, step=2 -> next cycle o_busy=0, o_op=0,
//    o_phase=0, no o_done. A new i_start restarts at phase 0.
//  - Start while busy: extra i_start at cycle 5 -> busy count still 20 and
//    exactly one o_done.
//  - rst_n asserted at phase=3 -> outputs 0 immediately (async, before the next
//    edge); no o_done after release.
//    SORT_PAUSE_EN: i_pause=1 for 4 cycles at phase 2, step 1 -> o_op=0 and
//    phase/step held; busy totals 24 cycles.

Source files
------------

// File: rtl/shearsort_sequencer.sv
// shearsort_sequencer: central controller for an N x N PE mesh.
// Sequences a full shearsort of LOG_N row/column phase pairs followed by one
// final row phase. Each phase has N odd-even transposition steps. Each step's
// opcode is held for SORT_CYCLES cycles. The opcode and indices are registered
// and broadcast to every PE.
//
// Optional feature: define SORT_PAUSE_EN to add i_pause. While i_pause is high
// the sort freezes and drives NOP.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   i_start  start request, sampled only in IDLE
//   i_abort  abandon the sort in progress (priority over start)
//   i_pause  (SORT_PAUSE_EN only) freeze counters and drive NOP
//   o_busy   high from the first op cycle through the last op cycle
//   o_done   one-cycle pulse after a sort completes normally
//   o_op     broadcast opcode
//   o_snake  odd rows sort descending (row phases only)
//   o_phase  current phase index
//   o_step   current step index within the phase
module shearsort_sequencer #(
    parameter int unsigned N           = 4,
    parameter int unsigned LOG_N       = 2,
    parameter int unsigned SORT_CYCLES = 1,
    parameter int unsigned OP_WIDTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic                             i_abort,
`ifdef SORT_PAUSE_EN
    input  logic                             i_pause,
`endif
    output logic                             o_busy,
    output logic                             o_done,
    output logic [OP_WIDTH-1:0]              o_op,
    output logic                             o_snake,
    output logic [$clog2(2*LOG_N+1)-1:0]     o_phase,
    output logic [$clog2(N)-1:0]             o_step
);

    localparam int unsigned PHASE_W = $clog2(2*LOG_N+1);
    localparam int unsigned STEP_W  = $clog2(N);
    localparam int unsigned CYC_W   = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2*LOG_N);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(N-1);
    localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(SORT_CYCLES-1);

    localparam logic [OP_WIDTH-1:0] OP_NOP         = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_CS_ROW_EVEN = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_CS_ROW_ODD  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_CS_COL_EVEN = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_CS_COL_ODD  = OP_WIDTH'(8);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ROW       = 3'd1,
        S_COL       = 3'd2,
        S_FINAL_ROW = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [STEP_W-1:0]    step_q,  step_d;
    logic [CYC_W-1:0]     cyc_q,   cyc_d;
    logic [OP_WIDTH-1:0]  op_q,    op_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 snake_q, snake_d;
    logic                 pause_c;
    logic                 hold_c;

`ifdef SORT_PAUSE_EN
    assign pause_c = i_pause;
`else
    assign pause_c = 1'b0;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            step_q  <= '0;
            cyc_q   <= '0;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            snake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            cyc_q   <= cyc_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            snake_q <= snake_d;
        end
    end

    // Next state, counter advance and next-cycle output decode
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_d  = step_q;
        cyc_d   = cyc_q;
        op_d    = OP_NOP;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        snake_d = 1'b0;
        hold_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A simultaneous abort in IDLE is ignored, so start wins
                if (i_start) begin
                    state_d = S_ROW;
                    phase_d = '0;
                    step_d  = '0;
                    cyc_d   = '0;
                end
            end
            S_ROW, S_COL, S_FINAL_ROW: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    step_d  = '0;
                    cyc_d   = '0;
                end else if (pause_c) begin
                    hold_c = 1'b1;
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (phase_q == PHASE_LAST) begin
                            state_d = S_DONE;
                            phase_d = '0;
                        end else begin
                            phase_d = PHASE_W'(phase_q + 1'b1);
                            if (phase_d == PHASE_LAST)
                                state_d = S_FINAL_ROW;
                            else if (phase_d[0])
                                state_d = S_COL;
                            else
                                state_d = S_ROW;
                        end
                    end else begin
                        step_d = STEP_W'(step_q + 1'b1);
                    end
                end else begin
                    cyc_d = CYC_W'(cyc_q + 1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                step_d  = '0;
                cyc_d   = '0;
            end
        endcase

        // Outputs describe the cycle that state_d will occupy
        case (state_d)
            S_ROW, S_FINAL_ROW: begin
                busy_d  = 1'b1;
                snake_d = 1'b1;
                op_d    = step_d[0] ? OP_CS_ROW_ODD : OP_CS_ROW_EVEN;
            end
            S_COL: begin
                busy_d  = 1'b1;
                op_d    = step_d[0] ? OP_CS_COL_ODD : OP_CS_COL_EVEN;
            end
            S_DONE: begin
                done_d  = 1'b1;
            end
            default: begin
                busy_d  = 1'b0;
            end
        endcase

        // A paused cycle keeps busy/snake/indices but broadcasts NOP
        if (hold_c)
            op_d = OP_NOP;
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_op    = op_q;
    assign o_snake = snake_q;
    assign o_phase = phase_q;
    assign o_step  = step_q;

endmodule

// File: tb/tb_shearsort_sequencer.sv
// Testbench for shearsort_sequencer: one instance with SORT_CYCLES=1 and one
// with SORT_CYCLES=3. Expected opcode/phase/step for every op cycle come from
// the sort schedule itself (cycle index -> phase, step).
module tb_shearsort_sequencer;

    localparam int N     = 4;
    localparam int LOG_N = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, abort1, pause1;
    logic       start3, abort3, pause3;
    logic       busy1, done1, snake1;
    logic       busy3, done3, snake3;
    logic [3:0] op1, op3;
    logic [2:0] phase1, phase3;
    logic [1:0] step1, step3;

    int         sel;
    logic       cur_busy, cur_done, cur_snake;
    logic [3:0] cur_op;
    logic [2:0] cur_phase;
    logic [1:0] cur_step;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shearsort_sequencer #(.N(N), .LOG_N(LOG_N), .SORT_CYCLES(1), .OP_WIDTH(4)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start1),
        .i_abort (abort1),
`ifdef SORT_PAUSE_EN
        .i_pause (pause1),
`endif
        .o_busy  (busy1),
        .o_done  (done1),
        .o_op    (op1),
        .o_snake (snake1),
        .o_phase (phase1),
        .o_step  (step1)
    );

    shearsort_sequencer #(.N(N), .LOG_N(LOG_N), .SORT_CYCLES(3), .OP_WIDTH(4)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start3),
        .i_abort (abort3),
`ifdef SORT_PAUSE_EN
        .i_pause (pause3),
`endif
        .o_busy  (busy3),
        .o_done  (done3),
        .o_op    (op3),
        .o_snake (snake3),
        .o_phase (phase3),
        .o_step  (step3)
    );

    always_comb begin
        if (sel == 0) begin
            cur_busy = busy1; cur_done = done1; cur_snake = snake1;
            cur_op = op1; cur_phase = phase1; cur_step = step1;
        end else begin
            cur_busy = busy3; cur_done = done3; cur_snake = snake3;
            cur_op = op3; cur_phase = phase3; cur_step = step3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ab, input logic pa);
        if (sel == 0) begin start1 = st; abort1 = ab; pause1 = pa; end
        else          begin start3 = st; abort3 = ab; pause3 = pa; end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(cur_busy),  0);
        chk({tag, "_op"},    32'(cur_op),    0);
        chk({tag, "_done"},  32'(cur_done),  0);
        chk({tag, "_phase"}, 32'(cur_phase), 0);
        chk({tag, "_step"},  32'(cur_step),  0);
        chk({tag, "_snake"}, 32'(cur_snake), 0);
    endtask

    // One sort from IDLE. abort_at/extra_at/pause_at are op-cycle indices, -1 = none.
    task automatic run_sort(input int sc, input int abort_at, input int extra_at,
                            input int pause_at, input logic start_with_abort);
        int total;
        int busy_cnt;
        total    = (2*LOG_N + 1) * N * sc;
        busy_cnt = 0;
        drive(1'b1, start_with_abort, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < total; i++) begin
            int idx, p, s, eop;
            idx = i / sc;
            p   = idx / N;
            s   = idx % N;
            eop = ((p % 2) == 1 ? 7 : 5) + (s % 2);
            busy_cnt += int'(cur_busy);
            chk("sort_busy",  32'(cur_busy),  1);
            chk("sort_op",    32'(cur_op),    32'(eop));
            chk("sort_phase", 32'(cur_phase), 32'(p));
            chk("sort_step",  32'(cur_step),  32'(s));
            chk("sort_snake", 32'(cur_snake), ((p % 2) == 0) ? 1 : 0);
            chk("sort_done",  32'(cur_done),  0);
            drive(i == extra_at, 1'b0, 1'b0);
            if (i == abort_at) begin
                drive(1'b0, 1'b1, 1'b0);
                @(negedge clk);
                drive(1'b0, 1'b0, 1'b0);
                chk_idle("abort_next");
                @(negedge clk);
                chk_idle("abort_after");
                return;
            end
`ifdef SORT_PAUSE_EN
            if (i == pause_at) begin
                drive(1'b0, 1'b0, 1'b1);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    busy_cnt += int'(cur_busy);
                    chk("pause_op",    32'(cur_op),    0);
                    chk("pause_busy",  32'(cur_busy),  1);
                    chk("pause_phase", 32'(cur_phase), 32'(p));
                    chk("pause_step",  32'(cur_step),  32'(s));
                    if (k == 3) drive(1'b0, 1'b0, 1'b0);
                end
            end
`endif
            @(negedge clk);
        end
        chk("busy_total", 32'(busy_cnt), 32'(total + ((pause_at >= 0) ? 4 : 0)));
        chk("end_busy", 32'(cur_busy), 0);
        chk("end_done", 32'(cur_done), 1);
        chk("end_op",   32'(cur_op),   0);
        drive(1'b1, 1'b0, 1'b0);    // start during DONE must be ignored
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        chk_idle("post_done");
        @(negedge clk);
        chk_idle("post_idle");
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 0;
        start1 = 0; abort1 = 0; pause1 = 0;
        start3 = 0; abort3 = 0; pause3 = 0;
        #3;
        chk_idle("reset1");
        sel = 1;
        chk_idle("reset3");
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("no_start1");
        sel = 1;
        chk_idle("no_start3");
        sel = 0;

        // Abort in IDLE has no effect
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        chk_idle("idle_abort");

        run_sort(1, -1, -1, -1, 1'b0);
        run_sort(1, -1, 5, -1, 1'b0);
        run_sort(1, 6, -1, -1, 1'b0);       // abort at phase 1, step 2
        run_sort(1, -1, -1, -1, 1'b1);      // start + abort together in IDLE

        for (int r = 0; r < 6; r++) begin
            int ab, ex;
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 19)) : -1;
            ex = int'($urandom_range(0, 19));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sort(1, ab, ex, -1, 1'($urandom_range(0, 1)));
        end

        sel = 1;
        run_sort(3, -1, -1, -1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            int ab;
            ab = int'($urandom_range(0, 59));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sort(3, ab, int'($urandom_range(0, 59)), -1, 1'b0);
        end
        sel = 0;

`ifdef SORT_PAUSE_EN
        run_sort(1, -1, -1, 9, 1'b0);       // pause at phase 2, step 1
`endif

        // Asynchronous reset mid-sort at phase 3
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        chk("pre_rst_phase", 32'(cur_phase), 3);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(cur_done), 0);
        end
        chk_idle("post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
